// File: rtl/compare_tree_pipe.sv
// Pipelined max/min comparator tree. One tree level per register stage; a beat
// carries its own mode, and the lowest channel index wins among equal extremes.
module compare_tree_pipe #(
  parameter int WIDTH  = 4,
  parameter int N_CH   = 8,
  parameter int IDX_W  = $clog2(N_CH),
  parameter int LEVELS = $clog2(N_CH)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [N_CH*WIDTH-1:0]   i_data,
  input  logic [N_CH-1:0]         i_mask,
  input  logic                    i_mode,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [WIDTH-1:0]        o_value,
  output logic [IDX_W-1:0]        o_index,
  output logic                    o_any,
  output logic                    o_tie
);

  typedef struct packed {
    logic             prs;
    logic             tie;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] val;
  } node_t;

  // Nodes of all levels are packed into one array: level L starts at N_CH - (N_CH >> L).
  localparam int N_NODES = N_CH - 1;
  localparam int ROOT    = N_CH - 2;
  localparam int MODE_N  = (LEVELS > 1) ? LEVELS - 1 : 1;

  node_t              r_node [N_NODES];
  node_t              w_nxt  [N_NODES];
  logic [LEVELS-1:0]  r_vld;
  logic [MODE_N-1:0]  r_mode;
  logic               w_en;

  function automatic node_t f_merge(input logic mode, input node_t a, input node_t b);
    node_t r;
    r = '0;
    if (a.prs && b.prs) begin
      if (a.val == b.val) begin
        r     = a;
        r.tie = 1'b1;
      end else if ((a.val > b.val) ^ mode) begin
        r = a;
      end else begin
        r = b;
      end
    end else if (a.prs) begin
      r = a;
    end else if (b.prs) begin
      r = b;
    end
    return r;
  endfunction

  assign o_valid = r_vld[LEVELS-1];
  assign w_en    = i_ready | ~o_valid;
  assign o_ready = w_en;

  generate
    for (genvar gi = 0; gi < LEVELS; gi++) begin : g_lvl
      localparam int OFF = N_CH - (N_CH >> gi);
      localparam int CNT = N_CH >> (gi + 1);
      for (genvar gj = 0; gj < CNT; gj++) begin : g_node
        node_t w_a;
        node_t w_b;
        logic  w_mode;
        if (gi == 0) begin : g_leaf
          // Gating presence with i_valid turns bubbles into all-zero nodes.
          assign w_a    = {i_mask[2*gj] & i_valid, 1'b0, IDX_W'(2*gj),
                           i_data[2*gj*WIDTH +: WIDTH]};
          assign w_b    = {i_mask[2*gj+1] & i_valid, 1'b0, IDX_W'(2*gj+1),
                           i_data[(2*gj+1)*WIDTH +: WIDTH]};
          assign w_mode = i_mode;
        end else begin : g_inner
          localparam int POFF = N_CH - (N_CH >> (gi - 1));
          assign w_a    = r_node[POFF + 2*gj];
          assign w_b    = r_node[POFF + 2*gj + 1];
          assign w_mode = r_mode[gi-1];
        end
        assign w_nxt[OFF + gj] = f_merge(w_mode, w_a, w_b);
      end
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld  <= '0;
      r_mode <= '0;
      for (int n = 0; n < N_NODES; n++) r_node[n] <= '0;
    end else if (w_en) begin
      r_vld[0]  <= i_valid;
      r_mode[0] <= i_mode;
      for (int l = 1; l < LEVELS; l++) r_vld[l] <= r_vld[l-1];
      for (int l = 1; l < LEVELS - 1; l++) r_mode[l] <= r_mode[l-1];
      for (int n = 0; n < N_NODES; n++) r_node[n] <= w_nxt[n];
    end
  end

  assign o_any   = r_node[ROOT].prs;
  assign o_value = r_node[ROOT].prs ? r_node[ROOT].val : '0;
  assign o_index = r_node[ROOT].prs ? r_node[ROOT].idx : '0;
  assign o_tie   = r_node[ROOT].prs ? r_node[ROOT].tie : 1'b0;

endmodule

// File: tb/tb_compare_tree_pipe.sv
// Bench for compare_tree_pipe (N_CH=8, WIDTH=4): table vectors, stream,
// backpressure and mid-stream reset, with a queue scoreboard on the output.
module tb_compare_tree_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_data = '0;
  logic [7:0]  i_mask = '0;
  logic        i_mode = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [3:0]  o_value;
  logic [2:0]  o_index;
  logic        o_any;
  logic        o_tie;

  typedef struct packed {
    logic [3:0] val;
    logic [2:0] idx;
    logic       any;
    logic       tie;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  mask;
    logic        mode;
    logic [3:0]  ev;
    logic [2:0]  ei;
    logic        ea;
    logic        et;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_a;
  exp_t mon_e;
  exp_t bp_exp0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_out = 0;
  int   n0;
  int   b;
  logic acc;
  vec_t tbl[10];
  logic [31:0] bp_d[4];
  logic [7:0]  bp_m[4];

  compare_tree_pipe #(.WIDTH(4), .N_CH(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_mask  (i_mask),
    .i_mode  (i_mode),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_value (o_value),
    .o_index (o_index),
    .o_any   (o_any),
    .o_tie   (o_tie)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Linear-scan reference: first strictly better value wins, tie if any other equals it.
  function automatic exp_t model(input logic [31:0] d, input logic [7:0] m, input logic md);
    exp_t       e;
    int         cnt;
    logic [3:0] v;
    e   = '0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (m[k]) begin
        v = d[k*4 +: 4];
        if (!e.any || (md ? (v < e.val) : (v > e.val))) begin
          e.any = 1'b1;
          e.val = v;
          e.idx = 3'(k);
        end
      end
    end
    for (int k = 0; k < 8; k++)
      if (m[k] && d[k*4 +: 4] == e.val) cnt++;
    e.tie = (cnt > 1);
    return e;
  endfunction

  task automatic drive(input logic [31:0] d, input logic [7:0] m, input logic md);
    i_valid = 1'b1;
    i_data  = d;
    i_mask  = m;
    i_mode  = md;
  endtask

  // Scoreboard: push on input transfer, pop and compare on output transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (o_valid && i_ready) begin
        mon_a = {o_value, o_index, o_any, o_tie};
        n_out++;
        $display("out #%0d val=%0d idx=%0d any=%0b tie=%0b", n_out, o_value, o_index, o_any, o_tie);
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected: got result %0h, want no output", mon_a);
        end else begin
          mon_e = sb_q.pop_front();
          chk("sb_result", 32'(mon_a), 32'(mon_e));
        end
      end
      if (i_valid && o_ready) sb_q.push_back(model(i_data, i_mask, i_mode));
    end
  end

  initial begin
    tbl[0] = '{32'h40197293, 8'hFF, 1'b0, 4'd9,  3'd1, 1'b1, 1'b1};
    tbl[1] = '{32'h40197293, 8'hDF, 1'b1, 4'd0,  3'd6, 1'b1, 1'b0};
    tbl[2] = '{32'h40197293, 8'h00, 1'b0, 4'd0,  3'd0, 1'b0, 1'b0};
    tbl[3] = '{32'h40197293, 8'hFF, 1'b1, 4'd0,  3'd6, 1'b1, 1'b0};
    tbl[4] = '{32'h40197293, 8'h10, 1'b0, 4'd9,  3'd4, 1'b1, 1'b0};
    tbl[5] = '{32'hFFFFFFFF, 8'hFF, 1'b1, 4'd15, 3'd0, 1'b1, 1'b1};
    tbl[6] = '{32'hFFFFFFFF, 8'h80, 1'b0, 4'd15, 3'd7, 1'b1, 1'b0};
    tbl[7] = '{32'h00000000, 8'h0C, 1'b0, 4'd0,  3'd2, 1'b1, 1'b1};
    tbl[8] = '{32'h40197293, 8'h12, 1'b1, 4'd9,  3'd1, 1'b1, 1'b1};
    tbl[9] = '{32'h40197293, 8'hEE, 1'b0, 4'd9,  3'd1, 1'b1, 1'b0};

    // Reset and idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_value", 32'(o_value), 32'd0);
    chk("rst_o_index", 32'(o_index), 32'd0);
    chk("rst_o_any",   32'(o_any),   32'd0);
    chk("rst_o_tie",   32'(o_tie),   32'd0);
    chk("rst_o_ready", 32'(o_ready), 32'd1);

    // Single beats with hand-computed results, checked at exactly 3 cycles latency
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 drive(tbl[i].data, tbl[i].mask, tbl[i].mode);
      @(posedge clk);
      #1 i_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("tbl%0d_early", i), 32'(o_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      $display("vec %0d mask=%02h mode=%0b -> val=%0d idx=%0d any=%0b tie=%0b",
               i, tbl[i].mask, tbl[i].mode, o_value, o_index, o_any, o_tie);
      chk($sformatf("tbl%0d_valid", i), 32'(o_valid), 32'd1);
      chk($sformatf("tbl%0d_value", i), 32'(o_value), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_index", i), 32'(o_index), 32'(tbl[i].ei));
      chk($sformatf("tbl%0d_any", i),   32'(o_any),   32'(tbl[i].ea));
      chk($sformatf("tbl%0d_tie", i),   32'(o_tie),   32'(tbl[i].et));
    end

    // Back-to-back stream, alternating mode
    @(posedge clk);
    #1;
    for (int k = 0; k < 9; k++) begin
      if (k < 6) drive($urandom, 8'($urandom), k[0]);
      else i_valid = 1'b0;
      @(negedge clk);
      if (k == 2) chk("b2b_latency", 32'(o_valid), 32'd0);
      if (k >= 3) chk($sformatf("b2b_valid%0d", k - 3), 32'(o_valid), 32'd1);
      @(posedge clk);
      #1;
    end

    // Backpressure: 4 beats offered while downstream stalls
    repeat (4) @(posedge clk);
    #1;
    n0 = n_out;
    for (int k = 0; k < 4; k++) begin
      bp_d[k] = $urandom;
      bp_m[k] = 8'($urandom) | 8'h01;
    end
    bp_exp0 = model(bp_d[0], bp_m[0], 1'b0);
    i_ready = 1'b0;
    b = 0;
    drive(bp_d[0], bp_m[0], 1'b0);
    repeat (6) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        b++;
        if (b < 4) drive(bp_d[b], bp_m[b], b[0]);
        else i_valid = 1'b0;
      end
    end
    chk("bp_accepted", 32'(b), 32'd3);
    repeat (3) begin
      @(negedge clk);
      chk("bp_o_ready", 32'(o_ready), 32'd0);
      chk("bp_hold_valid", 32'(o_valid), 32'd1);
      chk("bp_hold_value", 32'(o_value), 32'(bp_exp0.val));
      chk("bp_hold_index", 32'(o_index), 32'(bp_exp0.idx));
    end
    @(posedge clk);
    #1 i_ready = 1'b1;
    for (int t = 0; t < 20 && b < 4; t++) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        b++;
        i_valid = 1'b0;
      end
    end
    chk("bp_fourth_accepted", 32'(b), 32'd4);
    for (int t = 0; t < 20 && sb_q.size() != 0; t++) @(posedge clk);
    @(negedge clk);
    chk("bp_drain_empty", 32'(sb_q.size()), 32'd0);
    chk("bp_out_count", 32'(n_out - n0), 32'd4);

    // Reset with 3 beats in flight
    @(posedge clk);
    #1 i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive($urandom, 8'hFF, k[0]);
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    rst_n   = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_o_valid", 32'(o_valid), 32'd0);
    chk("mrst_o_value", 32'(o_value), 32'd0);
    chk("mrst_o_any",   32'(o_any),   32'd0);
    chk("mrst_o_ready", 32'(o_ready), 32'd1);
    @(posedge clk);
    #1 i_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("mrst_no_stale", 32'(o_valid), 32'd0);
    end
    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/compare_tree_pipe.md
Name: compare_tree_pipe

Overview:
- Pipelined, parametrised magnitude comparator tree. Each accepted beat carries N_CH unsigned WIDTH-bit candidates with per-candidate enable mask.
- Selects extreme value (max or min, per-beat mode), winning channel index, any-valid flag and tie flag.
- Successor to the single-pair value comparator. Used in compression stages to pick the best candidate (e.g. longest match length) from parallel lanes.
- valid/ready stream interface on both sides.

Parameters:
- WIDTH, 4, candidate value width in bits (>=1).
- N_CH, 8, number of candidate channels; power of two, >=2.
- IDX_W, $clog2(N_CH), winning-index width; derived, do not override.
- LEVELS, $clog2(N_CH), tree depth = pipeline latency; derived.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset. Synchronous, active-low.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block can accept a beat this cycle.
- i_data  in  N_CH*WIDTH  candidates. Channel k is at bits [k*WIDTH +: WIDTH].
- i_mask  in  N_CH  1 = channel k participates.
- i_mode  in  1  0 = select maximum, 1 = select minimum. Sampled with the beat.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_value  out  WIDTH  winning value.
- o_index  out  IDX_W  winning channel index.
- o_any  out  1  at least one masked-in candidate existed.
- o_tie  out  1  another masked-in candidate equals the winning value.

Behaviour:
- Clocking and reset:
  - Single clock domain. All state updates on posedge i_clk.
  - Reset when i_rst_n=0 at a clock edge. This clears every stage valid bit and all stage data.
  - Outputs after reset: o_valid=0, o_value=0, o_index=0, o_any=0, o_tie=0. o_ready=1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight beats; no partial result is ever presented.
- Pipeline structure:
  - LEVELS register stages. Stage L holds N_CH>>(L+1) nodes. Each node is {value, index, present, tie}, plus the mode bit per stage.
  - Leaf pairs (2j, 2j+1) compare in stage 0. The last stage drives the outputs directly (registered).
- Flow control:
  - Global enable en = i_ready | ~o_valid. o_ready = en.
  - Input transfers when i_valid & o_ready. Output transfers when o_valid & i_ready.
  - When en=1 all stages shift one level; stage 0 loads (i_valid & o_ready). When en=0 all stages hold.
  - Bubbles are not collapsed.
  - Latency: LEVELS cycles from input transfer to o_valid when unstalled. Throughput is 1 beat/cycle while i_ready=1.
  - Outputs are stable while o_valid=1 and i_ready=0.
- Node merge (left child A = lower indices, right child B):
  - Neither present: present=0, value=0, index=0, tie=0.
  - Exactly one present: that child wins, keeping its value, index and tie.
  - Both present with A.value == B.value: A wins (lower index), tie=1.
  - Both present, mode=0: the larger value wins. mode=1: the smaller value wins. The winner keeps its own tie.
  - Comparison is unsigned over the full WIDTH. No truncation; values pass through unchanged.
- Leaf init:
  - present = i_mask[k], value = i_data slice, index = k, tie = 0.
- Final results:
  - o_any = root present.
  - If the root is not present, o_value/o_index/o_tie are forced to 0.
  - Tie-break is always lowest index among equal extremes.
- Mode is captured per beat and travels with it; a mode change between consecutive beats is legal.
- i_data/i_mask/i_mode are ignored when the beat is not transferred.

Test Plan (N_CH=8, WIDTH=4, latency 3):
- Reset then idle -> o_valid=0, o_value=0, o_index=0, o_any=0, o_tie=0, o_ready=1.
- Max select: data ch0..7 = {3,9,2,7,9,1,0,4}, mask=0xFF, mode=0 -> 3 cycles later o_value=9, o_index=1, o_tie=1, o_any=1.
- Min select with mask: same data, mask=0xDF (ch5 off), mode=1 -> o_value=0, o_index=6, o_tie=0. Then mask=0x00 -> o_any=0, o_value=0, o_index=0.
- Back-to-back stream: 6 consecutive beats, alternating mode, i_ready=1 -> 6 consecutive o_valid cycles, in order, each matching a reference model.
- Backpressure: hold i_ready=0 while 4 beats are pushed -> o_ready drops after 3 accepted beats, o_value/o_index held stable. Release -> all results drain in order with no loss or duplication.
- Reset mid-stream: assert i_rst_n=0 for one cycle with 3 beats in flight -> o_valid=0 next cycle, and no stale results appear afterwards.
